// File: rtl/resta_flotante.sv
// Sequential binary32 subtractor (out = A - B): flush-to-zero operands, bit-serial
// alignment and normalization, truncating arithmetic, start/done handshake.
module resta_flotante (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        OP    = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state_reg, state_next;

    logic        sign_reg, sign_next;
    logic        eff_sub_reg, eff_sub_next;
    logic [7:0]  exp_reg, exp_next;
    logic [7:0]  diff_reg, diff_next;
    logic [23:0] man_l_reg, man_l_next;
    logic [23:0] man_s_reg, man_s_next;
    logic [24:0] sum_reg, sum_next;
    logic [31:0] out_reg, out_next;
    logic        ovf_reg, ovf_next;
    logic        unf_reg, unf_next;
    logic        inv_reg, inv_next;

    // Operand unpacking: index 0 is A, index 1 is B with its sign flipped,
    // so the rest of the datapath only ever computes A + (-B).
    logic [31:0] op_word [2];
    logic [7:0]  op_exp  [2];
    logic [23:0] op_man  [2];
    logic        op_sign [2];
    logic        op_zero [2];
    logic        op_nan  [2];

    assign op_word[0] = A;
    assign op_word[1] = B;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_exp[gi]  = op_word[gi][30:23];
            assign op_zero[gi] = (op_exp[gi] == 8'd0);
            assign op_nan[gi]  = (op_exp[gi] == 8'hFF);
            assign op_man[gi]  = op_zero[gi] ? 24'd0 : {1'b1, op_word[gi][22:0]};
            if (gi == 0) begin : g_sign_a
                assign op_sign[gi] = op_word[gi][31];
            end else begin : g_sign_b
                assign op_sign[gi] = ~op_word[gi][31];
            end
        end
    endgenerate

    // Magnitude ordering on {exp, mantissa}; ties keep A as the larger operand.
    logic        a_ge;
    logic [7:0]  exp_l, exp_s;
    logic [23:0] man_l, man_s;
    logic        sign_l, sign_s;
    logic [7:0]  diff_cap;

    assign a_ge     = {op_exp[0], op_man[0]} >= {op_exp[1], op_man[1]};
    assign exp_l    = a_ge ? op_exp[0]  : op_exp[1];
    assign exp_s    = a_ge ? op_exp[1]  : op_exp[0];
    assign man_l    = a_ge ? op_man[0]  : op_man[1];
    assign man_s    = a_ge ? op_man[1]  : op_man[0];
    assign sign_l   = a_ge ? op_sign[0] : op_sign[1];
    assign sign_s   = a_ge ? op_sign[1] : op_sign[0];
    assign diff_cap = exp_l - exp_s;

    logic [7:0] exp_inc;
    logic [7:0] exp_dec;
    assign exp_inc = exp_reg + 8'd1;
    assign exp_dec = exp_reg - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sign_next    = sign_reg;
        eff_sub_next = eff_sub_reg;
        exp_next     = exp_reg;
        diff_next    = diff_reg;
        man_l_next   = man_l_reg;
        man_s_next   = man_s_reg;
        sum_next     = sum_reg;
        out_next     = out_reg;
        ovf_next     = ovf_reg;
        unf_next     = unf_reg;
        inv_next     = inv_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (op_nan[0] || op_nan[1]) begin
                        out_next   = QNAN;
                        ovf_next   = 1'b0;
                        unf_next   = 1'b0;
                        inv_next   = 1'b1;
                        state_next = DONE;
                    end else if (op_zero[0] && op_zero[1]) begin
                        out_next   = 32'd0;
                        ovf_next   = 1'b0;
                        unf_next   = 1'b0;
                        inv_next   = 1'b0;
                        state_next = DONE;
                    end else begin
                        sign_next    = sign_l;
                        eff_sub_next = sign_l ^ sign_s;
                        exp_next     = exp_l;
                        diff_next    = diff_cap;
                        man_l_next   = man_l;
                        man_s_next   = man_s;
                        state_next   = (diff_cap != 8'd0) ? ALIGN : OP;
                    end
                end
            end

            ALIGN: begin
                // Beyond 24 positions every mantissa bit would fall off anyway.
                if (diff_reg > 8'd24) begin
                    man_s_next = 24'd0;
                    diff_next  = 8'd0;
                    state_next = OP;
                end else begin
                    man_s_next = man_s_reg >> 1;
                    diff_next  = diff_reg - 8'd1;
                    if (diff_reg == 8'd1) begin
                        state_next = OP;
                    end
                end
            end

            OP: begin
                if (eff_sub_reg) begin
                    sum_next = {1'b0, man_l_reg} - {1'b0, man_s_reg};
                end else begin
                    sum_next = {1'b0, man_l_reg} + {1'b0, man_s_reg};
                end
                state_next = NORM;
            end

            NORM: begin
                if (sum_reg == 25'd0) begin
                    out_next   = 32'd0;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                    inv_next   = 1'b0;
                    state_next = DONE;
                end else if (sum_reg[24]) begin
                    sum_next   = sum_reg >> 1;
                    exp_next   = exp_inc;
                    unf_next   = 1'b0;
                    inv_next   = 1'b0;
                    if (exp_inc == 8'hFF) begin
                        out_next = {sign_reg, 8'hFF, 23'd0};
                        ovf_next = 1'b1;
                    end else begin
                        out_next = {sign_reg, exp_inc, sum_reg[23:1]};
                        ovf_next = 1'b0;
                    end
                    state_next = DONE;
                end else if (sum_reg[23]) begin
                    out_next   = {sign_reg, exp_reg, sum_reg[22:0]};
                    ovf_next   = 1'b0;
                    unf_next   = 1'b0;
                    inv_next   = 1'b0;
                    state_next = DONE;
                end else if (exp_reg == 8'd1) begin
                    // No denormals: anything below the smallest normal flushes to +0.
                    out_next   = 32'd0;
                    ovf_next   = 1'b0;
                    unf_next   = 1'b1;
                    inv_next   = 1'b0;
                    state_next = DONE;
                end else begin
                    sum_next = sum_reg << 1;
                    exp_next = exp_dec;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_reg    <= 1'b0;
            eff_sub_reg <= 1'b0;
            exp_reg     <= 8'd0;
            diff_reg    <= 8'd0;
            man_l_reg   <= 24'd0;
            man_s_reg   <= 24'd0;
            sum_reg     <= 25'd0;
            out_reg     <= 32'd0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            inv_reg     <= 1'b0;
        end else begin
            sign_reg    <= sign_next;
            eff_sub_reg <= eff_sub_next;
            exp_reg     <= exp_next;
            diff_reg    <= diff_next;
            man_l_reg   <= man_l_next;
            man_s_reg   <= man_s_next;
            sum_reg     <= sum_next;
            out_reg     <= out_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
            inv_reg     <= inv_next;
        end
    end

    assign out       = out_reg;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;
    assign invalid   = inv_reg;
    assign done      = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_resta_flotante.sv
// Self-checking bench for resta_flotante: directed cases, random operands
// against an arithmetic reference model, busy/start interplay and async reset.
module tb_resta_flotante;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] out;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    int n_cmp = 0;
    int n_bad = 0;

    resta_flotante dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .out       (out),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on unpacked fields, then latency from
    // the alignment distance and the number of normalizing left shifts.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov,
                                  output logic un, output logic inv, output int lat);
        int ea, eb, el, es, diff, d, n, e;
        longint ma, mb, ml, ms, sum;
        logic sa, sbn, sl, ss;
        r = 32'd0; ov = 1'b0; un = 1'b0; inv = 1'b0; lat = 1;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            r = 32'h7FC0_0000; inv = 1'b1; return;
        end
        if (ea == 0 && eb == 0) return;
        ma = (ea == 0) ? 0 : 64'h80_0000 + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : 64'h80_0000 + longint'(b[22:0]);
        sa = a[31];
        sbn = ~b[31];
        if (longint'(ea) * 64'h100_0000 + ma >= longint'(eb) * 64'h100_0000 + mb) begin
            el = ea; es = eb; ml = ma; ms = mb; sl = sa; ss = sbn;
        end else begin
            el = eb; es = ea; ml = mb; ms = ma; sl = sbn; ss = sa;
        end
        diff = el - es;
        d = (diff == 0) ? 0 : (diff > 24) ? 1 : diff;
        if (diff > 24) ms = 0;
        else ms = ms >> diff;
        sum = (sl == ss) ? ml + ms : ml - ms;
        e = el;
        n = 1;
        if (sum == 0) begin
            r = 32'd0;
        end else if (sum >= 64'h100_0000) begin
            e = e + 1;
            if (e == 255) begin
                r = {sl, 8'hFF, 23'd0}; ov = 1'b1;
            end else begin
                r = {sl, e[7:0], sum[23:1]};
            end
        end else begin
            while (sum < 64'h80_0000 && e > 1) begin
                sum = sum * 2; e = e - 1; n = n + 1;
            end
            if (sum < 64'h80_0000) begin
                r = 32'd0; un = 1'b1;
            end else begin
                r = {sl, e[7:0], sum[22:0]};
            end
        end
        lat = 2 + d + n;
    endfunction

    // Issue one operation, scramble the inputs after sampling, and check the result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] r;
        logic ov, un, inv;
        int lat, k;
        model(a, b, r, ov, un, inv, lat);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
        end
        k = 1;
        while (done !== 1'b1 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k !== lat) begin
            n_bad++;
            $display("FAIL %s latency A=%h B=%h got=%0d want=%0d", tag, a, b, k, lat);
        end
        n_cmp++;
        if ({out, overflow, underflow, invalid} !== {r, ov, un, inv}) begin
            n_bad++;
            $display("FAIL %s result A=%h B=%h got=%h o%b u%b i%b want=%h o%b u%b i%b",
                     tag, a, b, out, overflow, underflow, invalid, r, ov, un, inv);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++; $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, done, busy);
        end
        $display("op %-10s A=%h B=%h out=%h ovf=%b unf=%b inv=%b lat=%0d", tag, a, b,
                 out, overflow, underflow, invalid, k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out, done, busy, overflow, underflow, invalid} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_state out=%h done=%b busy=%b o%b u%b i%b want all 0",
                     out, done, busy, overflow, underflow, invalid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(32'h3F80_0000, 32'h3F00_0000, "half");
        n_cmp++;
        if (out !== 32'h3F00_0000) begin
            n_bad++; $display("FAIL half_const got=%h want=3f000000", out);
        end
        do_op(32'h3F80_0000, 32'hBF80_0000, "carry");
        n_cmp++;
        if (out !== 32'h4000_0000) begin
            n_bad++; $display("FAIL carry_const got=%h want=40000000", out);
        end
        do_op(32'h4040_0000, 32'h4040_0000, "cancel");
        do_op(32'h3F80_0000, 32'h3080_0000, "diff30");
        do_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, "overflow");
        n_cmp++;
        if ({out, overflow} !== {32'h7F80_0000, 1'b1}) begin
            n_bad++; $display("FAIL ovf_const got=%h/%b want=7f800000/1", out, overflow);
        end
        do_op(32'h7FC0_0000, 32'h1234_5678, "nan_a");
        n_cmp++;
        if ({out, invalid} !== {32'h7FC0_0000, 1'b1}) begin
            n_bad++; $display("FAIL nan_const got=%h/%b want=7fc00000/1", out, invalid);
        end
        do_op(32'h4000_0000, 32'hFF80_0000, "inf_b");
        do_op(32'h0080_0001, 32'h0080_0000, "underflow");
        n_cmp++;
        if ({out, underflow} !== {32'h0000_0000, 1'b1}) begin
            n_bad++; $display("FAIL unf_const got=%h/%b want=0/1", out, underflow);
        end
        do_op(32'h0000_0000, 32'h8000_0000, "zeros");
        do_op(32'h0000_0000, 32'h3F80_0000, "zero_a");
        do_op(32'h4120_0000, 32'h0000_0000, "zero_b");
        do_op(32'hC000_0000, 32'h4000_0000, "neg_add");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int ea, eb, sel;
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 19));
            ea = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(1, 254));
            if (sel < 12) eb = ea + int'($urandom_range(0, 4)) - 2;
            else eb = int'($urandom_range(0, 254));
            if (eb < 0) eb = 0;
            if (eb > 254 && sel != 1) eb = 254;
            a = {$urandom_range(0, 1) == 1, ea[7:0], $urandom_range(0, 32'h7F_FFFF) & 32'h7F_FFFF};
            b = {$urandom_range(0, 1) == 1, eb[7:0], $urandom_range(0, 32'h7F_FFFF) & 32'h7F_FFFF};
            if (sel == 2) b = a;
            do_op(a, b, "random");
        end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        A = 32'h3F80_0000; B = 32'h3F00_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        A = 32'h4100_0000; B = 32'hC100_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (done === 1'b1) begin
                pulses++;
                n_cmp++;
                if (out !== 32'h3F00_0000) begin
                    n_bad++; $display("FAIL busy_ignore_out got=%h want=3f000000", out);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL busy_ignore_pulses got=%0d want=1", pulses);
        end
        $display("op busy_ign  done_pulses=%0d out=%h", pulses, out);
    endtask

    task automatic test_reset_mid_align();
        int pulses;
        A = 32'h3F80_0000; B = 32'h3B80_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out, done, busy, overflow, underflow, invalid} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_mid_align out=%h done=%b busy=%b o%b u%b i%b want all 0",
                     out, done, busy, overflow, underflow, invalid);
        end
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL reset_no_done got=%0d pulses want=0", pulses);
        end
        $display("op reset_mid pulses_after_reset=%0d", pulses);
        do_op(32'h3F80_0000, 32'h3B80_0000, "post_rst");
        n_cmp++;
        if (out !== 32'h3F7F_0000) begin
            n_bad++; $display("FAIL post_rst_const got=%h want=3f7f0000", out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_op($urandom & 32'hBFFF_FFFF | 32'h0080_0000, $urandom & 32'hBFFF_FFFF | 32'h0080_0000, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid_align();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
